// File: rtl/id_stage_pipe.sv
// Decode/issue stage: decodes one instruction per cycle, resolves operands
// through prioritised forwarding, raises the load-use stall, resolves
// jumps/branches with one delay slot and owns the registered ID/EX boundary.
module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_valid_i,
  input  logic [ADDR_W-1:0]           pc_i,
  input  logic [31:0]                 inst_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic [DATA_W-1:0]           rdata1_i,
  input  logic [DATA_W-1:0]           rdata2_i,
  input  logic [NUM_FWD-1:0]          fwd_we_i,
  input  logic [NUM_FWD*REG_AW-1:0]   fwd_waddr_i,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i,
  input  logic                        ex_is_load_i,
  output logic [REG_AW-1:0]           raddr1_o,
  output logic [REG_AW-1:0]           raddr2_o,
  output logic                        re1_o,
  output logic                        re2_o,
  output logic                        stallreq_o,
  output logic                        branch_flag_o,
  output logic [ADDR_W-1:0]           branch_target_addr_o,
  output logic                        ex_valid_o,
  output logic [ALUOP_W-1:0]          ex_aluop_o,
  output logic [ALUSEL_W-1:0]         ex_alusel_o,
  output logic [DATA_W-1:0]           ex_rdata1_o,
  output logic [DATA_W-1:0]           ex_rdata2_o,
  output logic [REG_AW-1:0]           ex_waddr_o,
  output logic                        ex_we_o,
  output logic [ADDR_W-1:0]           ex_return_addr_o,
  output logic                        ex_in_delayslot_o,
  output logic                        ex_inst_invalid_o
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                         OP_LW = 6'h23;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                         FN_JR = 6'h08, FN_JALR = 6'h09, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;

  // Internal aluop/alusel encodings shared with the EX stage.
  localparam logic [ALUOP_W-1:0] AOP_AND = ALUOP_W'(8'h24), AOP_OR = ALUOP_W'(8'h25),
                                 AOP_XOR = ALUOP_W'(8'h26), AOP_NOR = ALUOP_W'(8'h27),
                                 AOP_SLL = ALUOP_W'(8'h7C), AOP_SRL = ALUOP_W'(8'h02),
                                 AOP_SRA = ALUOP_W'(8'h03), AOP_JAL = ALUOP_W'(8'h50),
                                 AOP_LW  = ALUOP_W'(8'hE3), AOP_BR  = ALUOP_W'(8'h51);
  localparam logic [ALUSEL_W-1:0] SEL_NOP = '0, SEL_LOGIC = ALUSEL_W'(3'b001),
                                  SEL_SHIFT = ALUSEL_W'(3'b010), SEL_JB = ALUSEL_W'(3'b110),
                                  SEL_LS = ALUSEL_W'(3'b111);

  logic [5:0]          op, funct;
  logic [REG_AW-1:0]   rs, rt, rd;
  logic [15:0]         imm16;
  logic [ADDR_W-1:0]   pc4, pc8;

  assign op    = inst_i[31:26];
  assign funct = inst_i[5:0];
  assign rs    = REG_AW'(inst_i[25:21]);
  assign rt    = REG_AW'(inst_i[20:16]);
  assign rd    = REG_AW'(inst_i[15:11]);
  assign imm16 = inst_i[15:0];
  assign pc4   = pc_i + ADDR_W'(4);
  assign pc8   = pc_i + ADDR_W'(8);

  logic                d_we, d_invalid, d_jump, d_jreg, d_branch, d_bne, d_link;
  logic [REG_AW-1:0]   d_waddr;
  logic [DATA_W-1:0]   d_imm;
  logic [ALUOP_W-1:0]  d_aluop;
  logic [ALUSEL_W-1:0] d_alusel;

  // Instruction decode: read enables, destination, immediate and control class.
  always_comb begin
    re1_o = 1'b0; re2_o = 1'b0; d_we = 1'b0; d_waddr = '0; d_imm = '0;
    d_aluop = '0; d_alusel = SEL_NOP; d_invalid = 1'b0;
    d_jump = 1'b0; d_jreg = 1'b0; d_branch = 1'b0; d_bne = 1'b0; d_link = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            re1_o = 1'b1; re2_o = 1'b1; d_we = 1'b1; d_waddr = rd; d_alusel = SEL_LOGIC;
            d_aluop = (funct == FN_AND) ? AOP_AND : (funct == FN_OR) ? AOP_OR :
                      (funct == FN_XOR) ? AOP_XOR : AOP_NOR;
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            re1_o = 1'b1; re2_o = 1'b1; d_we = 1'b1; d_waddr = rd; d_alusel = SEL_SHIFT;
            d_aluop = (funct == FN_SLLV) ? AOP_SLL : (funct == FN_SRLV) ? AOP_SRL : AOP_SRA;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            // shift amount travels as the port-1 immediate
            re2_o = 1'b1; d_we = 1'b1; d_waddr = rd; d_alusel = SEL_SHIFT;
            d_imm = DATA_W'(inst_i[10:6]);
            d_aluop = (funct == FN_SLL) ? AOP_SLL : (funct == FN_SRL) ? AOP_SRL : AOP_SRA;
          end
          FN_JR: begin
            re1_o = 1'b1; d_jreg = 1'b1; d_aluop = AOP_BR; d_alusel = SEL_JB;
          end
          FN_JALR: begin
            re1_o = 1'b1; d_jreg = 1'b1; d_link = 1'b1; d_we = 1'b1;
            d_waddr = (rd == '0) ? REG_AW'(31) : rd;
            d_aluop = AOP_JAL; d_alusel = SEL_JB;
          end
          default: d_invalid = 1'b1;
        endcase
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        re1_o = 1'b1; d_we = 1'b1; d_waddr = rt; d_alusel = SEL_LOGIC;
        d_imm = DATA_W'(imm16);
        d_aluop = (op == OP_ORI) ? AOP_OR : (op == OP_ANDI) ? AOP_AND : AOP_XOR;
      end
      OP_LUI: begin
        // rs is r0 in a legal LUI, so OR with the shifted immediate
        re1_o = 1'b1; d_we = 1'b1; d_waddr = rt; d_alusel = SEL_LOGIC; d_aluop = AOP_OR;
        d_imm = {imm16, {(DATA_W-16){1'b0}}};
      end
      OP_LW: begin
        re1_o = 1'b1; d_we = 1'b1; d_waddr = rt; d_alusel = SEL_LS; d_aluop = AOP_LW;
        d_imm = {{(DATA_W-16){imm16[15]}}, imm16};
      end
      OP_BEQ, OP_BNE: begin
        re1_o = 1'b1; re2_o = 1'b1; d_branch = 1'b1; d_bne = (op == OP_BNE);
        d_aluop = AOP_BR; d_alusel = SEL_JB;
      end
      OP_J, OP_JAL: begin
        d_jump = 1'b1; d_alusel = SEL_JB;
        d_link = (op == OP_JAL); d_we = (op == OP_JAL);
        d_waddr = (op == OP_JAL) ? REG_AW'(31) : '0;
        d_aluop = (op == OP_JAL) ? AOP_JAL : AOP_BR;
      end
      default: d_invalid = 1'b1;
    endcase
  end

  assign raddr1_o = rs;
  assign raddr2_o = rt;

  logic [DATA_W-1:0] op1, op2;

  // Operand select; iterating oldest-first lets the youngest matching source win.
  always_comb begin
    op1 = rdata1_i;
    op2 = rdata2_i;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we_i[k] && fwd_waddr_i[k*REG_AW +: REG_AW] == raddr1_o)
        op1 = fwd_wdata_i[k*DATA_W +: DATA_W];
      if (fwd_we_i[k] && fwd_waddr_i[k*REG_AW +: REG_AW] == raddr2_o)
        op2 = fwd_wdata_i[k*DATA_W +: DATA_W];
    end
    if (raddr1_o == '0) op1 = '0;
    if (raddr2_o == '0) op2 = '0;
    if (!re1_o) op1 = d_imm;
    if (!re2_o) op2 = d_imm;
  end

  logic [REG_AW-1:0] ex_dst;
  assign ex_dst = fwd_waddr_i[REG_AW-1:0];

  assign stallreq_o = if_valid_i & ex_is_load_i & fwd_we_i[0] & (ex_dst != '0) &
                      ((re1_o & (raddr1_o == ex_dst)) | (re2_o & (raddr2_o == ex_dst)));

  logic              taken;
  logic [ADDR_W-1:0] target;

  // Control-transfer resolution and fetch redirect.
  always_comb begin
    taken  = 1'b0;
    target = '0;
    if (d_jump) begin
      taken  = 1'b1;
      target = {pc4[ADDR_W-1:28], inst_i[25:0], 2'b00};
    end else if (d_jreg) begin
      taken  = 1'b1;
      target = ADDR_W'(op1);
    end else if (d_branch) begin
      taken  = (op1 == op2) ^ d_bne;
      target = pc4 + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    end
    branch_flag_o        = taken & if_valid_i & ~stallreq_o & ~stall_i & ~flush_i;
    branch_target_addr_o = branch_flag_o ? target : '0;
  end

  logic ds_q;
  logic capture, bubble;

  assign bubble  = rst | flush_i | (~stall_i & (stallreq_o | ~if_valid_i));
  assign capture = ~rst & ~flush_i & ~stall_i & ~stallreq_o & if_valid_i;

  // ID/EX register: reset/flush/interlock bubbles, stall holds, otherwise capture.
  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_valid_o        <= 1'b0;
      ex_aluop_o        <= '0;
      ex_alusel_o       <= '0;
      ex_rdata1_o       <= '0;
      ex_rdata2_o       <= '0;
      ex_waddr_o        <= '0;
      ex_we_o           <= 1'b0;
      ex_return_addr_o  <= '0;
      ex_in_delayslot_o <= 1'b0;
      ex_inst_invalid_o <= 1'b0;
    end else if (capture) begin
      ex_valid_o        <= 1'b1;
      ex_aluop_o        <= d_aluop;
      ex_alusel_o       <= d_alusel;
      ex_rdata1_o       <= op1;
      ex_rdata2_o       <= op2;
      ex_waddr_o        <= d_waddr;
      ex_we_o           <= d_we;
      ex_return_addr_o  <= d_link ? pc8 : '0;
      ex_in_delayslot_o <= ds_q;
      ex_inst_invalid_o <= d_invalid;
    end
  end

  // Delay-slot tracker: any jump or branch (taken or not) marks the next issue.
  always_ff @(posedge clk) begin
    if (rst || flush_i)
      ds_q <= 1'b0;
    else if (capture)
      ds_q <= d_jump | d_jreg | d_branch;
  end

endmodule
